// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI register-bus transaction sequencer.
package spi_seq_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FB_W       = 8;
  localparam int unsigned CMD_RW_BIT = 7;

  localparam logic [DATA_W-1:0] STATUS_BYTE_DEF = 8'hA5;
  localparam logic [DATA_W-1:0] TURN_BYTE_DEF   = 8'h00;
  localparam logic [DATA_W-1:0] ERR_BYTE_DEF    = 8'hEE;
  localparam int unsigned       MAX_RD_LAT_DEF  = 4;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} seq_state_e;

  // Register-bus request as driven onto the bus
  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_req_t;

  function automatic logic [FB_W-1:0] sat_inc(input logic [FB_W-1:0] v);
    return (v == '1) ? v : v + FB_W'(1);
  endfunction

endpackage

// File: rtl/spi_rd_prefetch.sv
// Read prefetch: tracks one outstanding register read against a latency
// deadline, buffers the returned byte and forwards same-cycle returns.
module spi_rd_prefetch
  import spi_seq_pkg::*;
#(
  parameter int unsigned MAX_RD_LAT = MAX_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid,
  output logic              fwd_valid_c,
  output logic [DATA_W-1:0] fwd_data_c,
  output logic              timeout_c
);

  localparam int unsigned CNT_W = $clog2(MAX_RD_LAT + 1);

  logic              fetch_pending;
  logic [CNT_W-1:0]  lat_cnt;
  logic              pf_valid;
  logic [DATA_W-1:0] pf_data;
  logic              accept_c;

  // Returns after the deadline find fetch_pending already low and are dropped
  assign accept_c    = fetch_pending & reg_rvalid & ~clear;
  assign timeout_c   = fetch_pending & ~reg_rvalid & ~clear &
                       (lat_cnt == CNT_W'(MAX_RD_LAT));
  assign fwd_valid_c = pf_valid | accept_c;
  assign fwd_data_c  = pf_valid ? pf_data : reg_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pending <= 1'b0;
      lat_cnt       <= '0;
      pf_valid      <= 1'b0;
      pf_data       <= '0;
    end else if (clear) begin
      fetch_pending <= 1'b0;
      lat_cnt       <= '0;
      pf_valid      <= 1'b0;
    end else if (start) begin
      fetch_pending <= 1'b1;
      lat_cnt       <= '0;
      pf_valid      <= 1'b0;
    end else if (accept_c) begin
      fetch_pending <= 1'b0;
      pf_valid      <= 1'b1;
      pf_data       <= reg_rdata;
    end else if (timeout_c) begin
      fetch_pending <= 1'b0;
    end else if (fetch_pending) begin
      lat_cnt <= lat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_reg_sequencer.sv
// Frame-level controller above the SPI byte slave: decodes {rw, addr} command
// bytes into auto-incrementing register writes and prefetched reads.
module spi_reg_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] STATUS_BYTE = STATUS_BYTE_DEF,
  parameter logic [DATA_W-1:0] TURN_BYTE   = TURN_BYTE_DEF,
  parameter logic [DATA_W-1:0] ERR_BYTE    = ERR_BYTE_DEF,
  parameter int unsigned       MAX_RD_LAT  = MAX_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ssel_active,
  input  logic              byte_done,
  input  logic [DATA_W-1:0] byte_rx,
  output logic [DATA_W-1:0] byte_tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid,
  output logic              err_rd_late,
  output logic [FB_W-1:0]   frame_bytes
);

  seq_state_e        state_q, state_d;
  reg_req_t          req_q, req_d;
  logic              ssel_q;
  logic [DATA_W-1:0] byte_tx_d;
  logic              err_d;
  logic [FB_W-1:0]   fb_d;

  logic              pf_clear_c;
  logic              pf_start_c;
  logic              fwd_valid_c;
  logic [DATA_W-1:0] fwd_data_c;
  logic              timeout_c;

  assign reg_addr  = req_q.addr;
  assign reg_wdata = req_q.wdata;
  assign reg_wr    = req_q.wr;
  assign reg_rd    = req_q.rd;

  assign pf_clear_c = ~ssel_active | (state_q == IDLE);

  spi_rd_prefetch #(
    .MAX_RD_LAT (MAX_RD_LAT)
  ) u_prefetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (pf_clear_c),
    .start       (pf_start_c),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .fwd_valid_c (fwd_valid_c),
    .fwd_data_c  (fwd_data_c),
    .timeout_c   (timeout_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_d.wr   = 1'b0;
    req_d.rd   = 1'b0;
    byte_tx_d  = byte_tx;
    err_d      = err_rd_late;
    fb_d       = frame_bytes;
    pf_start_c = 1'b0;

    // Address advances the cycle after a write strobe
    if (req_q.wr) req_d.addr = req_q.addr + ADDR_W'(1);
    if (timeout_c) err_d = 1'b1;

    if (!ssel_active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!ssel_q) begin
            state_d   = CMD;
            fb_d      = '0;
            err_d     = 1'b0;
            byte_tx_d = STATUS_BYTE;
          end
        end
        CMD: begin
          if (byte_done) begin
            fb_d       = sat_inc(frame_bytes);
            req_d.addr = byte_rx[ADDR_W-1:0];
            if (byte_rx[CMD_RW_BIT]) begin
              state_d    = RD;
              byte_tx_d  = TURN_BYTE;
              req_d.rd   = 1'b1;
              pf_start_c = 1'b1;
            end else begin
              state_d   = WR;
              byte_tx_d = 8'h00;
            end
          end
        end
        WR: begin
          if (byte_done) begin
            fb_d        = sat_inc(frame_bytes);
            req_d.wdata = byte_rx;
            req_d.wr    = 1'b1;
            byte_tx_d   = 8'h00;
          end
        end
        RD: begin
          if (byte_done) begin
            fb_d       = sat_inc(frame_bytes);
            byte_tx_d  = fwd_valid_c ? fwd_data_c : ERR_BYTE;
            if (!fwd_valid_c) err_d = 1'b1;
            req_d.addr = req_q.addr + ADDR_W'(1);
            req_d.rd   = 1'b1;
            pf_start_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ssel_q      <= 1'b0;
      req_q       <= '0;
      byte_tx     <= STATUS_BYTE;
      err_rd_late <= 1'b0;
      frame_bytes <= '0;
    end else begin
      state_q     <= state_d;
      ssel_q      <= ssel_active;
      req_q       <= req_d;
      byte_tx     <= byte_tx_d;
      err_rd_late <= err_d;
      frame_bytes <= fb_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed self-checking bench for spi_reg_sequencer.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ssel_active = 1'b0;
  logic       byte_done = 1'b0;
  logic [7:0] byte_rx = 8'h00;
  logic [7:0] byte_tx;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_rvalid = 1'b0;
  logic       err_rd_late;
  logic [7:0] frame_bytes;

  int n_checks = 0;
  int n_fail = 0;

  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];
  int          both_hi = 0;
  bit          rsp_en = 1'b0;
  int          rsp_lat = 2;
  int          rd_cd = 0;
  logic [6:0]  rd_pa = 7'h00;
  logic [7:0]  t0, t1, t2, t3;

  spi_reg_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ssel_active (ssel_active),
    .byte_done   (byte_done),
    .byte_rx     (byte_rx),
    .byte_tx     (byte_tx),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .err_rd_late (err_rd_late),
    .frame_bytes (frame_bytes)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_mem(input logic [6:0] a);
    case (a)
      7'h05:   return 8'h11;
      7'h06:   return 8'h22;
      default: return 8'h40 + {1'b0, a};
    endcase
  endfunction

  // Bus monitor plus register-read responder with programmable latency
  always @(negedge clk) begin
    if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_q.push_back(reg_addr);
    if (reg_wr && reg_rd) both_hi++;
    reg_rvalid = 1'b0;
    if (rd_cd == 1) begin
      reg_rvalid = 1'b1;
      reg_rdata  = rd_mem(rd_pa);
    end
    if (rd_cd > 0) rd_cd--;
    if (reg_rd && rsp_en) begin
      rd_cd = rsp_lat;
      rd_pa = reg_addr;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output logic [7:0] tx);
    @(negedge clk);
    tx = byte_tx;
    byte_rx = b;
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    ssel_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    ssel_active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (byte_tx !== 8'hA5) begin n_fail++; $display("FAIL reset_byte_tx: got %h expected a5", byte_tx); end
    n_checks++;
    if ({reg_addr, reg_wdata, reg_wr, reg_rd, err_rd_late, frame_bytes} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h wr=%b rd=%b err=%b fb=%0d expected all zero",
               reg_addr, reg_wdata, reg_wr, reg_rd, err_rd_late, frame_bytes);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    wr_q.delete(); rd_q.delete();
    frame_start();
    send_byte(8'h10, 6, t0);
    send_byte(8'hAA, 6, t1);
    send_byte(8'hBB, 6, t2);
    n_checks++;
    if ({t0, t1, t2} !== 24'hA50000) begin n_fail++; $display("FAIL write_miso: got %h expected a50000", {t0, t1, t2}); end
    n_checks++;
    if (frame_bytes !== 8'd3) begin n_fail++; $display("FAIL write_frame_bytes: got %0d expected 3", frame_bytes); end
    n_checks++;
    if (wr_q.size() != 2) begin n_fail++; $display("FAIL write_count: got %0d expected 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      n_checks++;
      if ({wr_q[0], wr_q[1]} !== {7'h10, 8'hAA, 7'h11, 8'hBB}) begin
        n_fail++;
        $display("FAIL write_bus: got %h,%h expected 10:aa,11:bb", wr_q[0], wr_q[1]);
      end
    end
    n_checks++;
    if (reg_addr !== 7'h12) begin n_fail++; $display("FAIL write_addr_inc: got %h expected 12", reg_addr); end
    n_checks++;
    if (rd_q.size() != 0) begin n_fail++; $display("FAIL write_no_reads: got %0d reads expected 0", rd_q.size()); end
    frame_end();
  endtask

  task automatic test_read();
    wr_q.delete(); rd_q.delete();
    rsp_en = 1'b1; rsp_lat = 2;
    frame_start();
    send_byte(8'h85, 6, t0);
    send_byte(8'h00, 6, t1);
    send_byte(8'h00, 6, t2);
    send_byte(8'h00, 6, t3);
    n_checks++;
    if ({t0, t1, t2, t3} !== 32'hA5001122) begin n_fail++; $display("FAIL read_miso: got %h expected a5001122", {t0, t1, t2, t3}); end
    n_checks++;
    if (byte_tx !== 8'h47) begin n_fail++; $display("FAIL read_next_tx: got %h expected 47", byte_tx); end
    // Every byte_done in a read frame issues one read, the last one included
    n_checks++;
    if (rd_q.size() != 4) begin n_fail++; $display("FAIL read_count: got %0d expected 4", rd_q.size()); end
    if (rd_q.size() == 4) begin
      n_checks++;
      if ({rd_q[0], rd_q[1], rd_q[2], rd_q[3]} !== {7'h05, 7'h06, 7'h07, 7'h08}) begin
        n_fail++;
        $display("FAIL read_addrs: got %h %h %h %h expected 05 06 07 08", rd_q[0], rd_q[1], rd_q[2], rd_q[3]);
      end
    end
    n_checks++;
    if ({err_rd_late, frame_bytes} !== {1'b0, 8'd4}) begin
      n_fail++;
      $display("FAIL read_status: got err=%b fb=%0d expected err=0 fb=4", err_rd_late, frame_bytes);
    end
    n_checks++;
    if (wr_q.size() != 0) begin n_fail++; $display("FAIL read_no_writes: got %0d expected 0", wr_q.size()); end
    frame_end();
    rsp_en = 1'b0;
  endtask

  task automatic test_wrap();
    wr_q.delete();
    frame_start();
    send_byte(8'h7F, 6, t0);
    send_byte(8'hC1, 6, t1);
    send_byte(8'hC2, 6, t2);
    n_checks++;
    if (wr_q.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      n_checks++;
      if ({wr_q[0], wr_q[1]} !== {7'h7F, 8'hC1, 7'h00, 8'hC2}) begin
        n_fail++;
        $display("FAIL wrap_bus: got %h,%h expected 7f:c1,00:c2", wr_q[0], wr_q[1]);
      end
    end
    n_checks++;
    if (reg_addr !== 7'h01) begin n_fail++; $display("FAIL wrap_addr: got %h expected 01", reg_addr); end
    frame_end();
  endtask

  task automatic test_late_read();
    rd_q.delete();
    rsp_en = 1'b0;
    frame_start();
    send_byte(8'h83, 6, t0);
    n_checks++;
    if (err_rd_late !== 1'b1) begin n_fail++; $display("FAIL late_deadline_err: got %b expected 1", err_rd_late); end
    send_byte(8'h00, 6, t1);
    send_byte(8'h00, 6, t2);
    n_checks++;
    if ({t0, t1, t2} !== 24'hA500EE) begin n_fail++; $display("FAIL late_miso: got %h expected a500ee", {t0, t1, t2}); end
    n_checks++;
    if (rd_q.size() != 3) begin n_fail++; $display("FAIL late_read_count: got %0d expected 3", rd_q.size()); end
    frame_end();
    n_checks++;
    if (err_rd_late !== 1'b1) begin n_fail++; $display("FAIL late_err_hold: got %b expected 1", err_rd_late); end
    frame_start();
    n_checks++;
    if ({err_rd_late, frame_bytes, byte_tx} !== {1'b0, 8'd0, 8'hA5}) begin
      n_fail++;
      $display("FAIL late_frame_restart: got err=%b fb=%0d tx=%h expected err=0 fb=0 tx=a5", err_rd_late, frame_bytes, byte_tx);
    end
    // Data returning after the deadline must not reach byte_tx
    rsp_en = 1'b1; rsp_lat = 7;
    send_byte(8'h90, 6, t0);
    send_byte(8'h00, 6, t1);
    send_byte(8'h00, 6, t2);
    n_checks++;
    if ({t0, t1, t2} !== 24'hA500EE) begin n_fail++; $display("FAIL late_rvalid_ignored: got %h expected a500ee", {t0, t1, t2}); end
    frame_end();
    rsp_en = 1'b0;
  endtask

  task automatic test_forward();
    rsp_en = 1'b1; rsp_lat = 3;
    frame_start();
    send_byte(8'h8A, 2, t0);
    send_byte(8'h00, 2, t1);
    send_byte(8'h00, 2, t2);
    send_byte(8'h00, 2, t3);
    n_checks++;
    if ({t0, t1, t2, t3} !== 32'hA5004A4B) begin n_fail++; $display("FAIL fwd_miso: got %h expected a5004a4b", {t0, t1, t2, t3}); end
    n_checks++;
    if (err_rd_late !== 1'b0) begin n_fail++; $display("FAIL fwd_no_err: got %b expected 0", err_rd_late); end
    frame_end();
    rsp_en = 1'b0;
  endtask

  task automatic test_abort();
    wr_q.delete(); rd_q.delete();
    rsp_en = 1'b1; rsp_lat = 4;
    frame_start();
    send_byte(8'h86, 1, t0);
    @(negedge clk);
    ssel_active = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(8'h81, 2, t1);
    n_checks++;
    if (rd_q.size() != 1) begin n_fail++; $display("FAIL abort_read_count: got %0d expected 1", rd_q.size()); end
    n_checks++;
    if ({byte_tx, err_rd_late, frame_bytes} !== {8'h00, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL abort_hold: got tx=%h err=%b fb=%0d expected tx=00 err=0 fb=1", byte_tx, err_rd_late, frame_bytes);
    end
    rsp_en = 1'b0;
    // Write-frame byte that lands exactly as chip-select drops
    frame_start();
    send_byte(8'h30, 6, t0);
    @(negedge clk);
    ssel_active = 1'b0;
    byte_rx = 8'h99;
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_q.size() != 0) begin n_fail++; $display("FAIL deassert_byte_write: got %0d writes expected 0", wr_q.size()); end
    n_checks++;
    if (frame_bytes !== 8'd1) begin n_fail++; $display("FAIL deassert_byte_count: got %0d expected 1", frame_bytes); end
  endtask

  task automatic test_reset_mid_write();
    wr_q.delete();
    frame_start();
    send_byte(8'h20, 6, t0);
    @(negedge clk);
    byte_rx = 8'h77;
    byte_done = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    byte_done = 1'b0;
    ssel_active = 1'b0;
    n_checks++;
    if (byte_tx !== 8'hA5) begin n_fail++; $display("FAIL rst_mid_byte_tx: got %h expected a5", byte_tx); end
    n_checks++;
    if ({reg_addr, reg_wdata, reg_wr, reg_rd, err_rd_late, frame_bytes} !== 33'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got addr=%h wdata=%h wr=%b rd=%b err=%b fb=%0d expected all zero",
               reg_addr, reg_wdata, reg_wr, reg_rd, err_rd_late, frame_bytes);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_write: got %0d writes expected 0", wr_q.size()); end
  endtask

  task automatic test_saturate();
    frame_start();
    for (int i = 0; i < 254; i++) send_byte(8'h00, 1, t0);
    n_checks++;
    if (frame_bytes !== 8'd254) begin n_fail++; $display("FAIL sat_below: got %0d expected 254", frame_bytes); end
    for (int i = 0; i < 6; i++) send_byte(8'h00, 1, t0);
    n_checks++;
    if (frame_bytes !== 8'd255) begin n_fail++; $display("FAIL sat_limit: got %0d expected 255", frame_bytes); end
    frame_end();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_late_read();
    test_forward();
    test_abort();
    test_reset_mid_write();
    test_saturate();
    n_checks++;
    if (both_hi !== 0) begin n_fail++; $display("FAIL wr_rd_exclusive: got %0d overlap cycles expected 0", both_hi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
